// File: rtl/pkt_writer.sv
// pkt_writer: writer-side packet injector for a flit buffer.
//
// Accepts one 1- or 2-flit packet at a time from the local core. It waits
// until the buffer reports room for the whole packet, then strobes the flits
// in one at a time and waits for the buffer's packet-complete ack. If the ack
// does not arrive in time, the whole packet is re-sent. After MAX_RETRY
// re-sends the packet is dropped and err_drop pulses.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   pkt_valid/pkt_ready core handshake; a packet is accepted when both are high
//   pkt_len             0 = one flit, 1 = two flits
//   pkt_data0/1         head/tail payloads; bits [1:0] are replaced by framing
//   flit_out, write     buffer write interface (buffer latches on write rise)
//   capacity, ack       free slots and packet-complete flag from the buffer
//   busy                high whenever a packet is in flight
//   err_drop            one-cycle pulse when a packet is abandoned
//   sent_cnt            number of acked packets, wrapping at 8 bits
module pkt_writer #(
    parameter int BUFFER_SIZE = 5,
    parameter int ACK_TIMEOUT = 8,
    parameter int MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic        pkt_len,
    input  logic [31:0] pkt_data0,
    input  logic [31:0] pkt_data1,
    output logic [31:0] flit_out,
    output logic        write,
    input  logic [2:0]  capacity,
    input  logic        ack,
    output logic        busy,
    output logic        err_drop,
    output logic [7:0]  sent_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_WAIT_ACK
    } state_t;

    localparam logic [2:0] BUF_MAX  = 3'(BUFFER_SIZE);
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic        len_q, len_d;
    logic [29:0] data0_q, data0_d;
    logic [29:0] data1_q, data1_d;
    logic        idx_q, idx_d;
    logic [31:0] flit_q, flit_d;
    logic [3:0]  retry_q, retry_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        ack_q;
    logic        err_q, err_d;
    logic [7:0]  sent_q, sent_d;

    logic [2:0]  cap_eff;
    logic [2:0]  need;
    logic [31:0] head_flit;
    logic [31:0] tail_flit;
    logic        unused_bits;

    // The low two payload bits are always replaced by framing, so they are
    // never stored.
    assign unused_bits = ^{pkt_data0[1:0], pkt_data1[1:0]};

    // Anything above the physical depth is a buffer reporting glitch; clamp it.
    assign cap_eff   = (capacity > BUF_MAX) ? BUF_MAX : capacity;
    assign need      = len_q ? 3'd2 : 3'd1;

    // Framing: bit0 = flit index, head bit1 = packet length, tail bit1 = 0.
    assign head_flit = {data0_q, len_q, 1'b0};
    assign tail_flit = {data1_q, 1'b0, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= 1'b0;
            data0_q <= '0;
            data1_q <= '0;
            idx_q   <= 1'b0;
            flit_q  <= '0;
            retry_q <= '0;
            tmo_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            idx_q   <= idx_d;
            flit_q  <= flit_d;
            retry_q <= retry_d;
            tmo_q   <= tmo_d;
            ack_q   <= ack;
            err_q   <= err_d;
            sent_q  <= sent_d;
        end
    end

    // flit_out is only reloaded on the edge that enters SETUP, so it is stable
    // across the whole SETUP/STROBE/HOLD window around each write pulse.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        data0_d = data0_q;
        data1_d = data1_q;
        idx_d   = idx_q;
        flit_d  = flit_q;
        retry_d = retry_q;
        tmo_d   = tmo_q;
        err_d   = 1'b0;
        sent_d  = sent_q;

        case (state_q)
            S_IDLE: begin
                if (pkt_valid) begin
                    len_d   = pkt_len;
                    data0_d = pkt_data0[31:2];
                    data1_d = pkt_data1[31:2];
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // The whole packet must fit before the first strobe.
                if (cap_eff >= need) begin
                    idx_d   = 1'b0;
                    flit_d  = head_flit;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
            end
            S_STROBE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (idx_q < len_q) begin
                    idx_d   = 1'b1;
                    flit_d  = tail_flit;
                    state_d = S_SETUP;
                end else begin
                    tmo_d   = '0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (ack_q) begin
                    sent_d  = sent_q + 8'd1;
                    retry_d = '0;
                    state_d = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 4'd1;
                        state_d = S_CHECK;
                    end else begin
                        err_d   = 1'b1;
                        retry_d = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Decoded straight from the state so an async reset drops write at once.
    assign pkt_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign write     = (state_q == S_STROBE);
    assign flit_out  = flit_q;
    assign err_drop  = err_q;
    assign sent_cnt  = sent_q;

endmodule

// File: doc/pkt_writer.md
Name: pkt_writer

Overview:
Writer-side packet injector that drives the flit buffer's write interface (flit data, write strobe) and consumes its capacity and ack outputs. It accepts one 1- or 2-flit packet at a time from the local core and checks for free buffer space. It then strobes the flits into the buffer and waits for ack, re-sending the whole packet if ack does not arrive. It sits between the core's packet source and the buffer input.

Parameters:
BUFFER_SIZE, 5, depth of the downstream buffer; legal 1..7; capacity is never compared against more than this.
ACK_TIMEOUT, 8, cycles in WAIT_ACK before a retry; legal 1..255.
MAX_RETRY, 3, re-sends per packet before it is dropped; legal 0..15.

Ports:
clk  in  1  system clock, all state on rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
pkt_valid  in  1  core offers a packet.
pkt_ready  out  1  high in IDLE only; a packet is accepted on a cycle with pkt_valid && pkt_ready.
pkt_len  in  1  0 = one flit, 1 = two flits.
pkt_data0  in  32  head flit payload; bits [1:0] are overwritten.
pkt_data1  in  32  tail flit payload; bits [1:0] are overwritten; ignored when pkt_len=0.
flit_out  out  32  flit driven to buffer in.
write  out  1  write strobe to buffer; the buffer latches on its rising edge.
capacity  in  3  free slots reported by buffer.
ack  in  1  buffer packet-complete flag; level, cleared by the buffer on the next write.
busy  out  1  high in any state except IDLE.
err_drop  out  1  one-cycle pulse when a packet is abandoned after MAX_RETRY re-sends.
sent_cnt  out  8  count of packets acked; wraps 255->0.

Behaviour:
- Reset (async, rst_n=0): state IDLE, flit_out=0, write=0, pkt_ready=1, busy=0, err_drop=0, sent_cnt=0, retry and timeout counters 0. Reset mid-packet abandons the packet silently, with no err_drop.
- Flit encoding: bit0 = flit index (head 0, tail 1); head bit1 = pkt_len; tail bit1 = 0. Other bits pass through.
- On accept, data0, data1 and len are registered; the core may change its inputs afterwards.
- FSM states: IDLE, CHECK, SETUP, STROBE, HOLD, WAIT_ACK.
  - IDLE -> CHECK on accept.
  - CHECK: stays while capacity < (len+1); -> SETUP with index=0 otherwise.
  - SETUP: flit_out = flit[index], write=0 (one cycle of setup before the strobe).
  - STROBE: write=1, flit_out held (one cycle).
  - HOLD: write=0, flit_out held. If index < len: index++ -> SETUP. Otherwise -> WAIT_ACK, timeout counter cleared.
  - WAIT_ACK: ack sampled registered.
    - ack=1: sent_cnt++, retry cleared -> IDLE.
    - timeout reaches ACK_TIMEOUT with retry < MAX_RETRY: retry++ -> CHECK.
    - timeout reaches ACK_TIMEOUT with retry == MAX_RETRY: err_drop pulse, retry cleared -> IDLE.
- Capacity is checked only in CHECK, never between flits of a packet. The whole packet must fit before the first strobe.
- write is never high for two consecutive cycles. flit_out changes only in SETUP.
- Minimum accept-to-ack-wait latency: 1-flit packet reaches WAIT_ACK 4 cycles after accept; 2-flit packet after 7 cycles.
- ack already high on entry to WAIT_ACK (stale from the previous packet) cannot occur, because the buffer clears ack on the first strobe. Ack is honoured on the first WAIT_ACK cycle.
- capacity > BUFFER_SIZE is treated as BUFFER_SIZE.
- pkt_valid held while busy has no effect; there is no queueing.

Test Plan:
- Reset then 1-flit packet: pkt_len=0, data0=32'h0000a2c3, capacity=5, ack rises 1 cycle after the strobe -> flit_out=32'h0000a2c0, single write pulse, sent_cnt=1, pkt_ready back high.
- 2-flit packet: len=1, data0=32'h1234_5678, data1=32'hdead_beef -> flits 32'h1234567a then 32'hdeadbeed, two 1-cycle write pulses 3 cycles apart, ack honoured only after the second.
- Backpressure: capacity=1 with a 2-flit packet -> FSM held in CHECK with no write; capacity raised to 2 -> strobes begin 2 cycles later.
- Ack timeout: ack held 0, MAX_RETRY=3, ACK_TIMEOUT=8 -> 4 full sends (head re-sent each time), then a single-cycle err_drop pulse, sent_cnt unchanged, IDLE.
- Retry recovery: first ack missing, ack given on retry 1 -> exactly 2 sends, sent_cnt++, no err_drop.
- Async reset asserted during STROBE -> write=0 immediately (no clock needed), all outputs at reset values, next packet sent normally.
